// File: rtl/serial_multiplier_pkg.sv
// Shared definitions for the serial multiplier: FSM encoding, product
// width and the Curve25519 prime used by the downstream reduction stage.
package serial_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Width of the product bus; matches the A input of serial_modulo.
  localparam int PROD_W = 512;

  // P = 2^255 - 19
  localparam logic [255:0] CURVE_P = {1'b0, {255{1'b1}}} - 256'd18;

endpackage

// File: rtl/serial_multiplier_if.sv
// Handshake and data bundle between a requester and the serial multiplier.
interface serial_multiplier_if
  import serial_multiplier_pkg::*;
#(
  parameter int N = 255
);
  logic              start;
  logic [N-1:0]      X;
  logic [N-1:0]      Y;
  logic [PROD_W-1:0] product;
  logic              busy;
  logic              done;

  modport master (
    output start, X, Y,
    input  product, busy, done
  );

  modport slave (
    input  start, X, Y,
    output product, busy, done
  );
endinterface

// File: rtl/serial_multiplier.sv
// Shift-and-add unsigned multiplier: one multiplier bit per clock, LSB
// first, exact 2N-bit result zero-extended onto a 512-bit product bus.
module serial_multiplier
  import serial_multiplier_pkg::*;
#(
  parameter int N = 255
) (
  input  logic                clk,
  input  logic                reset,
  serial_multiplier_if.slave  bus
);

  localparam int              CW       = (N > 1) ? $clog2(N) : 1;
  localparam int              AW       = 2 * N;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      x_q, x_d;
  logic [N-1:0]      y_q, y_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     addend_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Partial product contributed by the multiplier bit selected by the counter.
  always_comb begin
    addend_s = '0;
    if (y_q[cnt_q]) begin
      addend_s = AW'(x_q) << cnt_q;
    end else begin
      addend_s = '0;
    end
  end

  // Next-state and datapath control: capture in IDLE, accumulate in MUL,
  // publish the result in FIN.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d     = bus.X;
          y_d     = bus.Y;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_MUL;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + addend_s;
        busy_d = 1'b1;
        // The counter parks on the last index rather than wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FIN: begin
        product_d = PROD_W'(acc_q);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously,
  // which also aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_serial_multiplier.sv
// Randomized self-checking bench for serial_multiplier (N = 255) against a
// plain wide-integer multiplication model.
module tb_serial_multiplier;
  import serial_multiplier_pkg::*;

  localparam int N       = 255;
  localparam int LAT     = N + 2;   // negedges from start drive to done visible
  localparam int TIMEOUT = 400;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  serial_multiplier_if #(.N(N)) bus ();

  serial_multiplier #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact unsigned product in 512-bit arithmetic.
  function automatic logic [511:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [511:0] ea;
    logic [511:0] eb;
    ea = {257'd0, a};
    eb = {257'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    r = r >> $urandom_range(0, 200);
    return r[N-1:0];
  endfunction

  // Called at a negedge: present operands with start for one cycle.
  task automatic start_job(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.X     = a;
    bus.Y     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int lat_in, output int lat, output int bc);
    lat = lat_in;
    bc  = 0;
    while (bus.done !== 1'b1 && lat < TIMEOUT) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    int lat;
    int bc;
    logic [511:0] exp_p;
    exp_p = ref_mul(a, b);
    start_job(a, b);
    wait_done(1, lat, bc);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    n_cmp++;
    if (bc !== N + 1) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, N + 1);
    end
    n_cmp++;
    if (bus.product !== exp_p) begin
      n_bad++;
      $display("FAIL %s product: got %0h expected %0h", name, bus.product, exp_p);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width: got %b expected 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (bus.product !== 512'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got p=%0h d=%b b=%b expected 0/0/0", bus.product, bus.done, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_small();
    run_and_check("small_2x3", 255'd2, 255'd3);
  endtask

  task automatic test_zero();
    run_and_check("zero_x", 255'd0, {255{1'b1}});
  endtask

  task automatic test_max();
    logic [511:0] exp_max;
    exp_max = (512'd1 << 510) - (512'd1 << 256) + 512'd1;
    run_and_check("max_x_max", {255{1'b1}}, {255{1'b1}});
    n_cmp++;
    if (bus.product !== exp_max) begin
      n_bad++;
      $display("FAIL max_closed_form: got %0h expected %0h", bus.product, exp_max);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_and_check("random", rand_op(), rand_op());
    end
  endtask

  task automatic test_hold();
    logic [511:0] held;
    int bad_cycles;
    held = bus.product;
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      bus.X = rand_op();
      bus.Y = rand_op();
      @(negedge clk);
      if (bus.product !== held || bus.done !== 1'b0 || bus.busy !== 1'b0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL idle_hold: got %0d disturbed cycles expected 0", bad_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2, a3, b3;
    int lat;
    int bc;
    a1 = rand_op(); b1 = rand_op();
    a2 = rand_op(); b2 = rand_op();
    a3 = rand_op(); b3 = rand_op();
    start_job(a1, b1);
    repeat (9) @(negedge clk);
    start_job(a2, b2);                  // must be ignored while busy
    wait_done(11, lat, bc);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL busy_restart latency: got %0d expected %0d", lat, LAT);
    end
    n_cmp++;
    if (bus.product !== ref_mul(a1, b1)) begin
      n_bad++;
      $display("FAIL busy_restart product: got %0h expected %0h", bus.product, ref_mul(a1, b1));
    end
    start_job(a3, b3);                  // issued in the done cycle
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", bus.done, bus.busy);
    end
    wait_done(1, lat, bc);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL b2b latency: got %0d expected %0d", lat, LAT);
    end
    n_cmp++;
    if (bus.product !== ref_mul(a3, b3)) begin
      n_bad++;
      $display("FAIL b2b product: got %0h expected %0h", bus.product, ref_mul(a3, b3));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    int spurious;
    start_job(rand_op() | 255'd1, rand_op() | 255'd1);
    repeat (99) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.product !== 512'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got p=%0h d=%b b=%b expected 0/0/0", bus.product, bus.done, bus.busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    spurious = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_bad++;
      $display("FAIL aborted_job_activity: got %0d cycles expected 0", spurious);
    end
    run_and_check("after_reset", rand_op(), rand_op());
  endtask

  task automatic test_modulo_chain();
    logic [N-1:0]  op;
    logic [511:0]  p_ext;
    logic [511:0]  red;
    op    = CURVE_P[N-1:0] + 255'd5;
    p_ext = {256'd0, CURVE_P};
    run_and_check("mod_chain", op, op);
    red = bus.product % p_ext;
    n_cmp++;
    if (red !== 512'd25) begin
      n_bad++;
      $display("FAIL mod_chain_reduced: got %0d expected 25", red);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    clk       = 1'b0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
    test_reset();
    test_small();
    test_zero();
    test_max();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid_job();
    test_modulo_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_multiplier.md
SERIAL_MULTIPLIER -- requirements
Module: serial_multiplier

Interface
REQ-001 Parameter N, default 255: operand width in bits; legal range 2..256, so that 2N <= 512.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 X  input  N  multiplicand; captured on the start edge.
REQ-006 Y  input  N  multiplier; captured on the start edge.
REQ-007 product  output  512  exact X*Y, zero-extended; width matches the A input of serial_modulo.
REQ-008 busy  output  1  high while in MUL or FIN.
REQ-009 done  output  1  one-cycle pulse marking a valid, updated product.

Function
REQ-010 The block SHALL compute the exact unsigned integer product X*Y, with no modular reduction; operands >= 2^255-19 are legal.
REQ-011 The block SHALL use a state machine with states IDLE, MUL and FIN.
REQ-012 In IDLE with start=1, the block SHALL capture X and Y, clear the 2N-bit accumulator, set the bit counter to 0 and go to MUL.
REQ-013 In IDLE with start=0, the block SHALL hold all registers and the product.
REQ-014 In MUL, each cycle SHALL process one multiplier bit, LSB first: acc <= acc + (Y_reg[cnt] ? X_reg << cnt : 0), then cnt <= cnt + 1.
REQ-015 When cnt = N-1 is processed, the next state SHALL be FIN; the counter SHALL NOT wrap within one operation.
REQ-016 In FIN, the block SHALL load product with the accumulator (upper 512-2N bits 0), set done to 1 and return to IDLE.
REQ-017 done SHALL be high for exactly one cycle and SHALL clear on the next edge.
REQ-018 Latency: start sampled at edge k SHALL give done=1 and a valid product after edge k+N+1 (k+256 for N=255).
REQ-019 While busy=1, start SHALL be ignored, with no capture and no restart.
REQ-020 start=1 in the cycle where done=1 (state already IDLE) SHALL be accepted, allowing back-to-back operation with no idle gap.
REQ-021 product SHALL hold its value until the next FIN; X and Y may change freely after the start edge.
REQ-022 For N=255, product[511:510] SHALL always be 0; the maximum value is (2^255-1)^2 = 2^510 - 2^256 + 1.

Reset
REQ-023 reset=0 SHALL immediately force state to IDLE and clear acc, X_reg, Y_reg, cnt, product, done and busy to 0, independent of clk.
REQ-024 Reset asserted mid-MUL SHALL abort the operation without ever producing a done pulse.
REQ-025 After reset deassertion, the first start SHALL be honoured on the next rising edge.

Structure
REQ-026 Shared package: state encoding (IDLE=2'b00, MUL=2'b01, FIN=2'b10), product width 512, and the curve modulus constant P = 2^255-19.
REQ-027 The implementation SHALL be a single module with no sub-module; the counter width SHALL be $clog2(N).
REQ-028 done and product SHALL connect directly to start and A of the downstream serial_modulo; no additional buffering is required.

Verification
REQ-029 X=2, Y=3, start for 1 cycle -> busy high for 256 cycles, then done pulse with product=6.
REQ-030 X=0, Y=2^255-1 -> product=0, with done after 256 cycles.
REQ-031 X=Y=2^255-1 -> product=2^510 - 2^256 + 1.
REQ-032 Start a job, pulse start again 10 cycles in with different operands -> only the first result and one done pulse; then start in the done cycle -> second result exactly 256 cycles later.
REQ-033 Assert reset at cycle 100 of a job -> all outputs 0 immediately, no done; a new job after release completes correctly.
REQ-034 Chain with serial_modulo: X = Y = 2^255-19 + 5 -> final reduced result = 25.
